// File: rtl/seq_transmit.sv
// seq_transmit: sends an N-bit pattern MSB first, repeated max(reps,1) times per request.
module seq_transmit #(
  parameter int N      = 6,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      seq,
  input  logic [REPS_W-1:0] reps,
  input  logic              abort,
  output logic              ready,
  output logic              a,
  output logic              a_valid,
  output logic              last
);
  localparam int BW = $clog2(N);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            r_state;
  logic [N-1:0]      r_shreg;
  logic [N-1:0]      r_pat;
  logic [BW-1:0]     r_bit;
  logic [REPS_W-1:0] r_rep;
  logic              w_send;
  logic              w_end_pat;
  always_comb begin
    w_send    = r_state == SEND;
    w_end_pat = r_bit == BW'(N - 1);
    last      = w_send && w_end_pat && r_rep == '0;
    ready     = !w_send || last;
    a         = w_send && r_shreg[N-1];
    a_valid   = w_send;
  end
  // the pattern copy lets repetitions reload after the shift register has drained
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_pat   <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_rep   <= '0;
    end else if (start && ready) begin
      r_state <= SEND;
      r_shreg <= seq;
      r_pat   <= seq;
      r_bit   <= '0;
      r_rep   <= (reps == '0) ? '0 : reps - REPS_W'(1);
    end else if (w_send) begin
      if (!w_end_pat) begin
        r_shreg <= {r_shreg[N-2:0], 1'b0};
        r_bit   <= r_bit + BW'(1);
      end else if (r_rep != '0) begin
        r_shreg <= r_pat;
        r_bit   <= '0;
        r_rep   <= r_rep - REPS_W'(1);
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_transmit.sv
// tb_seq_transmit: queue-of-pending-bits model checked every cycle, plus literal stream checks.
module tb_seq_transmit;
  localparam int N = 6;
  logic       clk = 0;
  logic       reset = 1, start = 0, abort = 0;
  logic [5:0] seq = '0;
  logic [3:0] reps = '0;
  logic       ready, a, a_valid, last;
  int         n_tests = 0, n_fail = 0;
  bit         en = 0;
  bit         q[$];
  bit         acc;
  logic [63:0] log_bits, last_mask;
  int          cnt;

  seq_transmit #(.N(N), .REPS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .seq(seq), .reps(reps),
    .abort(abort), .ready(ready), .a(a), .a_valid(a_valid), .last(last)
  );

  always #5 clk = ~clk;

  // model: every accepted request appends its whole bit stream; one bit retires per edge
  always @(posedge clk) begin
    acc = start && (q.size() <= 1);
    if (reset || abort) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc)
        for (int r = 0; r < ((reps == 0) ? 1 : int'(reps)); r++)
          for (int b = N - 1; b >= 0; b--) q.push_back(seq[b]);
    end
  end

  always @(negedge clk) begin
    if (en) begin
      logic [3:0] exp_o;
      exp_o = {q.size() > 0 ? q[0] : 1'b0, q.size() > 0, q.size() == 1, q.size() <= 1};
      n_tests++;
      if ({a, a_valid, last, ready} !== exp_o) begin
        n_fail++;
        $display("FAIL model t=%0t {a,a_valid,last,ready} got %b exp %b", $time, {a, a_valid, last, ready}, exp_o);
      end
      if (a_valid === 1'b1) begin
        if (last === 1'b1) last_mask[cnt] = 1'b1;
        log_bits = {log_bits[62:0], a};
        cnt++;
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    log_bits = '0; last_mask = '0; cnt = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] s, input logic [3:0] r);
    seq = s; reps = r; start = 1; tick(); start = 0;
  endtask

  initial begin
    clr();
    tick(2);
    reset = 0; en = 1;
    @(negedge clk);
    chk("reset_outs", {60'd0, a, a_valid, last, ready}, 64'b0001);
    tick();
    // 1: single pattern
    clr(); send(6'b101101, 1); tick(8);
    chk("t1_cnt", cnt, 6); chk("t1_bits", log_bits, 64'b101101); chk("t1_last", last_mask, 64'd1 << 5);
    // 2: repetitions and reps=0
    clr(); send(6'b110010, 3); tick(20);
    chk("t2_cnt", cnt, 18); chk("t2_bits", log_bits, 64'b110010110010110010); chk("t2_last", last_mask, 64'd1 << 17);
    clr(); send(6'b110010, 0); tick(8);
    chk("t2_r0_cnt", cnt, 6); chk("t2_r0_bits", log_bits, 64'b110010);
    // 3: back-to-back on the last-bit cycle
    clr(); send(6'b111000, 1); tick(5); send(6'b000111, 1); tick(8);
    chk("t3_cnt", cnt, 12); chk("t3_bits", log_bits, 64'b111000000111);
    chk("t3_last", last_mask, (64'd1 << 5) | (64'd1 << 11));
    // 4: abort beats start
    clr(); send(6'b101010, 1); tick(2);
    abort = 1; seq = 6'b111111; start = 1; tick(); abort = 0; start = 0;
    @(negedge clk);
    chk("t4_idle", {61'd0, a_valid, last, ready}, 64'b001);
    tick(3);
    chk("t4_cnt", cnt, 3); chk("t4_bits", log_bits, 64'b101);
    clr(); send(6'b101010, 1); tick(8);
    chk("t4_full", log_bits, 64'b101010); chk("t4_full_cnt", cnt, 6);
    // 5: reset mid-transfer, then mid-transfer seq changes
    clr(); send(6'b110011, 1); tick(3);
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    chk("t5_rst_outs", {60'd0, a, a_valid, last, ready}, 64'b0001);
    chk("t5_rst_cnt", cnt, 4); chk("t5_rst_bits", log_bits, 64'b1100);
    tick(2);
    clr(); send(6'b100110, 1); seq = 6'b011001; reps = 4'd5; tick(); seq = 6'b111111; tick(7);
    chk("t5_stable", log_bits, 64'b100110); chk("t5_stable_cnt", cnt, 6);
    // 6: start while busy is dropped
    clr(); send(6'b011011, 1); tick();
    send(6'b111111, 1); tick(8);
    chk("t6_cnt", cnt, 6); chk("t6_bits", log_bits, 64'b011011);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_transmit.md
Name: seq_transmit

Overview:
- Parallel-to-serial sequence transmitter: accepts an N-bit pattern through a ready/start handshake and drives it onto a 1-bit serial line, MSB first, one bit per clock.
- Optionally repeats the pattern a programmable number of times per request.
- Feeds the serial-bit input of the team's N-bit sequence detectors. MSB-first order means the detector's shift buffer equals the pattern right after the last bit.

Parameters:
- N, 6, pattern width in bits (N >= 2).
- REPS_W, 4, width of the repetition-count input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; accepted only when ready=1.
- seq  input  N  pattern to send; captured on the accepting edge.
- reps  input  REPS_W  number of back-to-back copies; 0 is treated as 1; captured with seq.
- abort  input  1  cancel the current transfer.
- ready  output  1  block can accept start this cycle.
- a  output  1  serial data bit.
- a_valid  output  1  a carries a pattern bit this cycle.
- last  output  1  current bit is the final bit of the request.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset. It is sampled on the rising edge of clk and has priority over everything else.
- Reset values: state=IDLE, ready=1, a=0, a_valid=0, last=0, shift register=0, counters=0.
- States:
  - IDLE: a=0, a_valid=0, last=0, ready=1.
  - SEND: a=shreg[N-1], a_valid=1.
- Acceptance:
  - start is accepted when start=1 and ready=1 on a rising edge.
  - On that edge: shreg<=seq, bit_cnt<=0, rep_cnt<=max(reps,1)-1, state<=SEND.
  - Latency: the first bit (seq[N-1]) appears on a in the cycle immediately after the accepting edge.
- SEND, each edge:
  - If bit_cnt<N-1: shift shreg left by 1 and increment bit_cnt.
  - If bit_cnt==N-1 and rep_cnt!=0: reload shreg from the captured pattern copy, set bit_cnt<=0, decrement rep_cnt.
- Final bit:
  - last=1 when bit_cnt==N-1 and rep_cnt==0; last=0 otherwise.
  - ready=1 in SEND only while last=1, so back-to-back requests are accepted with no gap.
  - After the last bit: if start=1 on that edge, the new pattern is loaded and SEND continues, with the new MSB on the next cycle. Otherwise state<=IDLE.
- Total bits per request: N*max(reps,1), on consecutive cycles with a_valid held high throughout.
- Widths:
  - bit_cnt is $clog2(N) bits wide and never exceeds N-1.
  - rep_cnt is REPS_W bits wide and only counts down, so there is no wrap-around.
- Pattern and count stability: seq and reps are sampled only on the accepting edge. Changes to them mid-transfer have no effect.
- abort:
  - abort=1 on any edge forces state<=IDLE and clears the counters.
  - The outputs return to IDLE values on the next cycle. Any partially sent pattern is truncated.
  - abort has priority over start, including on a last-bit cycle, so start is not accepted that cycle.
  - abort in IDLE has no effect beyond blocking start.
- Reset mid-transfer: same effect as abort, plus the shift register is cleared. Reset wins over abort and start.
- start=1 while ready=0 is ignored and not queued.

Test Plan:
1. N=6, reset then seq=6'b101101, reps=1, start pulsed one cycle -> over the next 6 cycles a=1,0,1,1,0,1 with a_valid=1; last=1 only on the 6th bit; ready=0 for bits 1-5; IDLE values (a=0, a_valid=0, ready=1) on cycle 7.
2. seq=6'b110010, reps=3 -> 18 consecutive valid bits, pattern 110010 repeated 3 times; last only on bit 18. Then repeat with reps=0 -> exactly 6 bits.
3. Back-to-back: seq=6'b111000 accepted, then start with seq=6'b000111 held during the last-bit cycle -> 12 continuous valid bits 111000000111, no idle cycle between them; last on bits 6 and 12.
4. Abort: seq=6'b101010 sent, abort=1 together with start=1 on the edge after bit 3 -> only 3 bits (1,0,1) are sent, the new start is not accepted, the block is IDLE on the next cycle, and a later start sends a full pattern.
5. Reset: reset=1 during bit 4 of a transfer -> from the next cycle a=0, a_valid=0, last=0, ready=1. Changing seq mid-transfer in a separate run -> the original pattern is sent unchanged.
6. start while busy: start pulsed during bit 2 (ready=0) -> ignored, and exactly N bits are sent for the original request.
